// File: rtl/wb_clint.sv
// Wishbone pipelined CLINT slave: MSIP/MTIMECMP/MTIME register window,
// mtime prescaler, and registered software/timer interrupt levels.
module wb_clint #(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_wb_adr,
    input  logic [63:0]           i_wb_dat,
    output logic [63:0]           o_wb_dat,
    input  logic                  i_wb_we,
    input  logic [7:0]            i_wb_sel,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_cyc,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    input  logic [63:0]           i_mtime,
    input  logic [63:0]           i_mtimecmp,
    output logic [63:0]           o_mtime,
    output logic                  o_mtime_we,
    output logic [63:0]           o_mtimecmp,
    output logic                  o_mtimecmp_we,
    output logic                  o_msip,
    output logic                  o_mtip
);

    localparam logic [ADDR_WIDTH-1:0] MSIP_ADR     = ADDR_WIDTH'(16'h0000);
    localparam logic [ADDR_WIDTH-1:0] MTIMECMP_ADR = ADDR_WIDTH'(16'h4000);
    localparam logic [ADDR_WIDTH-1:0] MTIME_ADR    = ADDR_WIDTH'(16'hBFF8);
    localparam logic [15:0]           CNT_LAST     = 16'(TICK_DIV - 1);

    logic [63:0] r_wb_dat;
    logic        r_wb_ack;
    logic [63:0] r_mtime;
    logic        r_mtime_we;
    logic [63:0] r_mtimecmp;
    logic        r_mtimecmp_we;
    logic        r_msip;
    logic        r_mtip;
    logic [15:0] r_cnt;

    logic        w_acc;
    logic        w_wr;
    logic        w_hit_msip;
    logic        w_hit_cmp;
    logic        w_hit_time;
    logic        w_tick;
    logic [63:0] w_mask;
    logic [63:0] w_mtime_eff;
    logic [63:0] w_mtimecmp_eff;
    logic [63:0] w_rdata;

    // The CPU latches our write-back one edge late, so forward the pending value.
    assign w_mtime_eff    = r_mtime_we    ? r_mtime    : i_mtime;
    assign w_mtimecmp_eff = r_mtimecmp_we ? r_mtimecmp : i_mtimecmp;

    assign w_acc      = i_wb_cyc && i_wb_stb;
    assign w_wr       = w_acc && i_wb_we;
    assign w_hit_msip = (i_wb_adr[ADDR_WIDTH-1:3] == MSIP_ADR[ADDR_WIDTH-1:3]);
    assign w_hit_cmp  = (i_wb_adr[ADDR_WIDTH-1:3] == MTIMECMP_ADR[ADDR_WIDTH-1:3]);
    assign w_hit_time = (i_wb_adr[ADDR_WIDTH-1:3] == MTIME_ADR[ADDR_WIDTH-1:3]);
    assign w_tick     = (r_cnt == CNT_LAST);

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_mask[i*8 +: 8] = {8{i_wb_sel[i]}};
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit_msip) begin
            w_rdata = {63'd0, r_msip};
        end else if (w_hit_cmp) begin
            w_rdata = w_mtimecmp_eff;
        end else if (w_hit_time) begin
            w_rdata = w_mtime_eff;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wb_dat      <= '0;
            r_wb_ack      <= 1'b0;
            r_mtime       <= '0;
            r_mtime_we    <= 1'b0;
            r_mtimecmp    <= '0;
            r_mtimecmp_we <= 1'b0;
            r_msip        <= 1'b0;
            r_mtip        <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_wb_ack <= w_acc;
            r_wb_dat <= (w_acc && !i_wb_we) ? w_rdata : '0;
            r_cnt    <= w_tick ? '0 : r_cnt + 16'd1;
            r_mtip   <= (w_mtime_eff >= w_mtimecmp_eff);

            // A bus write to MTIME overrides a coincident tick.
            if (w_wr && w_hit_time) begin
                r_mtime    <= (w_mtime_eff & ~w_mask) | (i_wb_dat & w_mask);
                r_mtime_we <= 1'b1;
            end else if (w_tick) begin
                r_mtime    <= w_mtime_eff + 64'd1;
                r_mtime_we <= 1'b1;
            end else begin
                r_mtime_we <= 1'b0;
            end

            if (w_wr && w_hit_cmp) begin
                r_mtimecmp    <= (w_mtimecmp_eff & ~w_mask) | (i_wb_dat & w_mask);
                r_mtimecmp_we <= 1'b1;
            end else begin
                r_mtimecmp_we <= 1'b0;
            end

            if (w_wr && w_hit_msip && i_wb_sel[0]) begin
                r_msip <= i_wb_dat[0];
            end
        end
    end

    assign o_wb_dat      = r_wb_dat;
    assign o_wb_ack      = r_wb_ack;
    assign o_wb_stall    = 1'b0;
    assign o_mtime       = r_mtime;
    assign o_mtime_we    = r_mtime_we;
    assign o_mtimecmp    = r_mtimecmp;
    assign o_mtimecmp_we = r_mtimecmp_we;
    assign o_msip        = r_msip;
    assign o_mtip        = r_mtip;

endmodule

// File: doc/wb_clint.md
Name: wb_clint

Overview:
- Wishbone pipelined slave for the core-local interruptor (CLINT), placed downstream of the CPU bus master behind the system interconnect.
- Decodes the CLINT register window.
- Returns the CPU-held mtime/mtimecmp on reads.
- Drives the CPU's mtime/mtimecmp write-back ports on bus writes and on prescaler ticks.
- Produces registered software (MSIP) and timer (MTIP) interrupt levels.

Parameters:
- TICK_DIV, 1, clock cycles per mtime increment; legal range 1..65535.
- ADDR_WIDTH, 16, number of i_wb_adr bits decoded; base decode is done upstream.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_wb_adr  in  ADDR_WIDTH  byte address; bits [2:0] ignored.
- i_wb_dat  in  64  write data.
- o_wb_dat  out  64  read data, valid with o_wb_ack.
- i_wb_we  in  1  write enable.
- i_wb_sel  in  8  byte lanes.
- i_wb_stb  in  1  strobe.
- i_wb_cyc  in  1  cycle.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  stall; tied 0.
- i_mtime  in  64  current mtime from the CPU.
- i_mtimecmp  in  64  current mtimecmp from the CPU.
- o_mtime  out  64  new mtime value to the CPU.
- o_mtime_we  out  1  one-cycle mtime write strobe.
- o_mtimecmp  out  64  new mtimecmp value to the CPU.
- o_mtimecmp_we  out  1  one-cycle mtimecmp write strobe.
- o_msip  out  1  software interrupt level.
- o_mtip  out  1  timer interrupt level.

Behaviour:
- Reset (i_reset low, asynchronous): all outputs 0, prescaler counter 0, pending-ack flag 0. The same applies mid-transaction: any in-flight ack is lost and no write strobe fires.
- Register map, on i_wb_adr[ADDR_WIDTH-1:3]:
  - 0x0000: MSIP; bit0 only, bits 63:1 read 0.
  - 0x4000: MTIMECMP.
  - 0xBFF8: MTIME.
  - Any other address: reads return 0, writes are ignored, and the access is still acked.
- Acceptance: a request is accepted every cycle in which i_wb_cyc && i_wb_stb. Back-to-back requests are allowed; there is no stall.
- Ack timing: exactly one o_wb_ack per accepted request, in the following cycle, with o_wb_dat registered alongside it. If i_wb_cyc is low in the ack cycle the ack is still driven, and the master ignores it.
- Effective values:
  - mtime_eff = o_mtime_we ? o_mtime : i_mtime.
  - mtimecmp_eff = o_mtimecmp_we ? o_mtimecmp : i_mtimecmp.
  - These forward the value being written this cycle, because the CPU latches it one edge later.
- Reads return mtime_eff or mtimecmp_eff as sampled in the acceptance cycle. i_wb_sel is ignored on reads.
- Writes merge byte lanes: new = (eff & ~mask) | (i_wb_dat & mask), where mask expands i_wb_sel per byte.
  - The result is registered to o_mtime or o_mtimecmp.
  - The matching _we is asserted for exactly one cycle, coincident with o_wb_ack.
  - An MSIP write with sel[0] set updates o_msip from i_wb_dat[0] at that same edge.
- Prescaler:
  - The counter counts 0..TICK_DIV-1 and a tick fires on the wrap.
  - On a tick: o_mtime <= mtime_eff + 1, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF wraps to 0), and o_mtime_we pulses for one cycle.
  - With TICK_DIV=1, a tick fires every cycle, so o_mtime_we is continuously high and o_mtime increments by 1 per cycle.
- Simultaneous events:
  - A bus MTIME write accepted in a tick cycle wins. The tick is discarded, but the prescaler still wraps.
  - Writes to MTIMECMP and ticks are independent, and both strobes may fire in the same cycle.
- MTIP:
  - o_mtip <= (mtime_eff >= mtimecmp_eff), unsigned 64-bit, registered each cycle.
  - It is therefore 1 cycle after the effective values change.
  - It is level-only; there is no latching.
- Nothing is written when no bus write is accepted and no tick fires. In those cycles o_mtime_we and o_mtimecmp_we are 0 and o_mtime/o_mtimecmp hold their values.

Test Plan:
- Reset and tick:
  - Stimulus: deassert i_reset with TICK_DIV=4 and i_mtime held at the last o_mtime.
  - Required response: all outputs 0 during reset; o_mtime_we pulses every 4th cycle; o_mtime goes 1, 2, 3.
- Byte-merged MTIMECMP write:
  - Stimulus: i_mtimecmp=0x1122334455667788; write 0x4000 with dat=0xAAAAAAAAAAAAAAAA, sel=0x0F.
  - Required response: the next cycle has ack=1, o_mtimecmp_we=1, o_mtimecmp=0x11223344AAAAAAAA.
- Read after write:
  - Stimulus: an MTIME write of 0x10 (sel=0xFF) followed immediately by a read of 0xBFF8, while i_mtime is still stale.
  - Required response: two consecutive acks; the read returns 0x10 via forwarding.
- Write-vs-tick collision and wrap:
  - Stimulus: an MTIME write of 0xFFFFFFFFFFFFFFFF accepted on a tick cycle.
  - Required response: o_mtime=0xFFFF...FF, with no +1 applied.
  - Stimulus: the next tick.
  - Required response: o_mtime=0.
- MTIP:
  - Stimulus: mtimecmp=5 with mtime counting up.
  - Required response: o_mtip rises exactly 1 cycle after mtime_eff reaches 5.
  - Stimulus: write mtimecmp=0xFFFF_FFFF_FFFF_FFFF.
  - Required response: o_mtip falls 1 cycle after the strobe.
- MSIP, unmapped address, mid-burst reset:
  - Stimulus: write 0x0000 with dat=1, sel=0x01.
  - Required response: o_msip=1.
  - Stimulus: read 0x2000.
  - Required response: acked with 0.
  - Stimulus: assert i_reset during an accepted write.
  - Required response: no ack, no _we, o_msip=0.
